// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Hazard sequencer for a 5-stage RV32 pipeline. It produces the
//               PC enable and the IF/ID, ID/EX and back-end enable/flush
//               controls from load-use, taken-branch and memory-wait
//               conditions. It also keeps a saturating count of cycles in
//               which the PC was held.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
    parameter int LOAD_USE_STALL = 1,   // bubbles per load-use hazard (1..7)
    parameter int BRANCH_PENALTY = 1,   // IF/ID squash cycles per taken branch (1..7)
    parameter int CNT_W          = 16   // stall_cycles width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic             branch_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             back_en,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_lu_stall = 2'd1;
    localparam logic [1:0] c_st_squash   = 2'd2;
    localparam logic [1:0] c_st_memwait  = 2'd3;

    // Counter reload values: the first bubble/squash cycle happens in RUN,
    // so the multi-cycle state covers the remaining N-1 cycles.
    localparam logic [2:0] c_lu_init = 3'(LOAD_USE_STALL - 1);
    localparam logic [2:0] c_br_init = 3'(BRANCH_PENALTY - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_ret;
    logic [2:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_ret_nxt;
    logic [2:0]       w_cnt_nxt;
    logic [1:0]       w_eval;
    logic             w_load_use;
    logic             w_pc_en;
    logic             w_ifid_en;
    logic             w_ifid_flush;
    logic             w_idex_flush;
    logic             w_back_en;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = idex_mem_read && (idex_rd != 5'd0) &&
                        ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                         (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    // After a memory wait the controller behaves as the state it left, in
    // the same cycle the wait ends, so no extra cycle is lost.
    assign w_eval = (r_state == c_st_memwait) ? r_ret : r_state;

    // State register, stall down-counter and resume-state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
            r_ret   <= c_st_run;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and pipeline control decode, priority dmem > branch > load-use > imem.
    always_comb begin
        w_state_nxt  = r_state;
        w_ret_nxt    = r_ret;
        w_cnt_nxt    = r_cnt;
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_back_en    = 1'b0;

        if (rst) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_state_nxt  = c_st_run;
            w_ret_nxt    = c_st_run;
            w_cnt_nxt    = 3'd0;
        end else if (dmem_busy) begin
            // Freeze everything; remember where to resume only on entry so
            // a long wait does not overwrite the resume state with MEMWAIT.
            w_state_nxt = c_st_memwait;
            if (r_state != c_st_memwait) begin
                w_ret_nxt = r_state;
            end
        end else begin
            w_state_nxt = w_eval;
            case (w_eval)
                c_st_run: begin
                    if (branch_taken) begin
                        w_pc_en      = 1'b1;
                        w_ifid_en    = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_back_en    = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            w_state_nxt = c_st_squash;
                            w_cnt_nxt   = c_br_init;
                        end
                    end else if (w_load_use) begin
                        w_idex_flush = 1'b1;
                        w_back_en    = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            w_state_nxt = c_st_lu_stall;
                            w_cnt_nxt   = c_lu_init;
                        end
                    end else if (imem_busy) begin
                        w_idex_flush = 1'b1;
                        w_back_en    = 1'b1;
                    end else begin
                        w_pc_en   = 1'b1;
                        w_ifid_en = 1'b1;
                        w_back_en = 1'b1;
                    end
                end
                c_st_lu_stall: begin
                    // EX holds a bubble here, so a branch cannot be resolving.
                    w_idex_flush = 1'b1;
                    w_back_en    = 1'b1;
                    w_cnt_nxt    = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = c_st_run;
                    end
                end
                c_st_squash: begin
                    w_ifid_en    = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_back_en    = 1'b1;
                    if (branch_taken) begin
                        // Fresh redirect: restart the squash window.
                        w_pc_en      = 1'b1;
                        w_idex_flush = 1'b1;
                        w_cnt_nxt    = c_br_init;
                        w_state_nxt  = (BRANCH_PENALTY > 1) ? c_st_squash : c_st_run;
                    end else begin
                        w_pc_en   = !imem_busy;
                        w_cnt_nxt = r_cnt - 3'd1;
                        if (r_cnt <= 3'd1) begin
                            w_state_nxt = c_st_run;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_st_run;
                end
            endcase
        end
    end

    // Performance counter of PC-hold cycles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign pc_en        = w_pc_en;
    assign ifid_en      = w_ifid_en;
    assign ifid_flush   = w_ifid_flush;
    assign idex_flush   = w_idex_flush;
    assign back_en      = w_back_en;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Scoreboard bench for pipeline_stall_controller. Instance A
//               uses default parameters; instance B uses LOAD_USE_STALL=3,
//               BRANCH_PENALTY=2, CNT_W=4. Both share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    // Output vector order: {pc_en, ifid_en, ifid_flush, idex_flush, back_en}
    localparam logic [4:0] c_reset = 5'b00110;
    localparam logic [4:0] c_norm  = 5'b11001;
    localparam logic [4:0] c_bub   = 5'b00011;
    localparam logic [4:0] c_frz   = 5'b00000;
    localparam logic [4:0] c_brn   = 5'b10111;
    localparam logic [4:0] c_sq    = 5'b10101;
    localparam logic [4:0] c_sqi   = 5'b00101;
    localparam logic [4:0] c_full  = 5'b11111;
    localparam logic [4:0] c_noen  = 5'b10111;  // ifid_en is don't-care under flush
    localparam logic [4:0] c_sqm   = 5'b10101;  // also ignore idex_flush on re-branch in SQUASH

    typedef struct {
        int         tid;
        bit         is_b;
        logic [4:0] exp;
        logic [4:0] msk;
        int         cnt;
    } exp_t;

    exp_t q[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ifid_rs1 = '0;
    logic [4:0] ifid_rs2 = '0;
    logic       ifid_use_rs1 = 1'b0;
    logic       ifid_use_rs2 = 1'b0;
    logic [4:0] idex_rd = '0;
    logic       idex_mem_read = 1'b0;
    logic       branch_taken = 1'b0;
    logic       imem_busy = 1'b0;
    logic       dmem_busy = 1'b0;

    logic       a_pc_en, a_ifid_en, a_ifid_flush, a_idex_flush, a_back_en;
    logic       b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_back_en;
    logic [15:0] a_stall;
    logic [3:0]  b_stall;
    logic [4:0]  a_out;
    logic [4:0]  b_out;

    int checks = 0;
    int errors = 0;

    assign a_out = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_flush, a_back_en};
    assign b_out = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_back_en};

    always #5 clk = ~clk;

    pipeline_stall_controller u_dut_a (
        .clk(clk), .rst(rst),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .back_en(a_back_en), .stall_cycles(a_stall)
    );

    pipeline_stall_controller #(
        .LOAD_USE_STALL(3), .BRANCH_PENALTY(2), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .back_en(b_back_en), .stall_cycles(b_stall)
    );

    // One cycle of stimulus; sel bit0 targets A, bit1 targets B; cv<0 skips the counter check.
    task automatic vec(input int tid, input int sel, input bit r,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input logic [4:0] rd,
                       input bit mr, input bit br, input bit ib, input bit db,
                       input logic [4:0] e, input logic [4:0] m, input int cv);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; ifid_rs1 = rs1; ifid_rs2 = rs2;
        ifid_use_rs1 = u1; ifid_use_rs2 = u2; idex_rd = rd;
        idex_mem_read = mr; branch_taken = br; imem_busy = ib; dmem_busy = db;
        x.tid = tid; x.exp = e; x.msk = m; x.cnt = cv;
        if (sel[0]) begin x.is_b = 1'b0; q.push_back(x); end
        if (sel[1]) begin x.is_b = 1'b1; q.push_back(x); end
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t x;
            logic [4:0]  act;
            logic [15:0] actc;
            x    = q.pop_front();
            act  = x.is_b ? b_out : a_out;
            actc = x.is_b ? {12'd0, b_stall} : a_stall;
            checks++;
            if ((act & x.msk) !== (x.exp & x.msk)) begin
                errors++;
                $display("FAIL t%0d dut_%s ctrl got=%b want=%b mask=%b", x.tid,
                         x.is_b ? "b" : "a", act, x.exp, x.msk);
            end
            if (x.cnt >= 0) begin
                checks++;
                if (actc !== 16'(x.cnt)) begin
                    errors++;
                    $display("FAIL t%0d dut_%s stall_cycles got=%0d want=%0d", x.tid,
                             x.is_b ? "b" : "a", actc, x.cnt);
                end
            end
        end
    end

    initial begin
        // Reset on both instances
        vec(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_reset, c_full, -1);
        vec(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_reset, c_full, 0);
        // A: load x5, ID uses rs2=x5 -> single bubble
        vec(1, 1, 0, 3, 5, 1, 1, 5, 1, 0, 0, 0, c_bub,  c_full, 0);
        vec(1, 1, 0, 3, 5, 1, 1, 5, 0, 0, 0, 0, c_norm, c_full, 1);
        vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm, c_full, 1);
        // A: rs2 matches but is not read -> no hazard
        vec(2, 1, 0, 3, 5, 1, 0, 5, 1, 0, 0, 0, c_norm, c_full, 1);
        // A: load to x0 never stalls
        vec(3, 1, 0, 0, 9, 1, 1, 0, 1, 0, 0, 0, c_norm, c_full, 1);
        vec(3, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, c_norm, c_full, 1);
        // A: imem wait
        vec(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_bub,  c_full, 1);
        vec(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm, c_full, 2);
        // A: branch beats load-use, no stall follows
        vec(5, 1, 0, 7, 2, 1, 0, 7, 1, 1, 0, 0, c_brn,  c_noen, 2);
        vec(5, 1, 0, 7, 2, 1, 0, 7, 0, 0, 0, 0, c_norm, c_full, 2);
        // A: dmem beats branch
        vec(6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, c_frz,  c_full, 2);
        vec(6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm, c_full, 3);
        // Reset again before exercising B
        vec(7, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_reset, c_full, -1);
        vec(7, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_reset, c_full, 0);
        // B: 3-bubble load-use, dmem wait of 4 after the 2nd bubble, branch ignored
        vec(8, 2, 0, 5, 6, 0, 1, 6, 1, 0, 0, 0, c_bub,  c_full, 0);
        vec(8, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_bub,  c_full, 1);
        for (int i = 0; i < 4; i++) begin
            vec(8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, c_frz, c_full, 2 + i);
        end
        vec(8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_bub,  c_full, 6);
        vec(8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm, c_full, 7);
        vec(8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm, c_full, 7);
        // B: second branch in SQUASH extends it to 3 flush cycles
        vec(9, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_brn,  c_noen, 7);
        vec(9, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_sq,   c_sqm,  7);
        vec(9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_sq,   c_noen, 7);
        vec(9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm, c_full, 7);
        // B: imem busy during SQUASH holds PC but the squash still counts
        vec(10, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_brn,  c_noen, 7);
        vec(10, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_sqi,  c_noen, 7);
        vec(10, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm, c_full, 8);
        // B: drive the 4-bit counter to saturation
        for (int i = 0; i < 8; i++) begin
            vec(11, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_bub, c_full, 8 + i);
        end
        vec(11, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_bub, c_full, 15);
        // B: reset in LU_STALL at saturation
        vec(12, 2, 0, 4, 0, 1, 0, 4, 1, 0, 0, 0, c_bub,   c_full, 15);
        vec(12, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_reset, c_full, 15);
        vec(12, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_reset, c_full, 0);
        vec(12, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm,  c_full, 0);
        vec(12, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_norm,  c_full, 0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
